// File: rtl/calc_operand_sequencer_if.sv
// ============================================================================
// calc_operand_sequencer_if : operand entry / calculator bus for the sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

interface calc_operand_sequencer_if;
   logic [3:0] sw;
   logic       enter;
   logic       clear;
   logic [3:0] calc_out;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] op;
   logic [3:0] result;
   logic       result_valid;
   logic       err;
   logic [2:0] stage;

   // master: user controls plus calculator; slave: the sequencer itself
   modport master (
      output sw, enter, clear, calc_out,
      input  a, b, op, result, result_valid, err, stage
   );

   modport slave (
      input  sw, enter, clear, calc_out,
      output a, b, op, result, result_valid, err, stage
   );
endinterface

`default_nettype wire

// File: rtl/calc_operand_sequencer.sv
// ============================================================================
// calc_operand_sequencer : collects A/op/B from switches, waits for the
// calculator to settle, then captures and holds its result.  Revision 1.0
// ============================================================================
`default_nettype none

module calc_operand_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   calc_operand_sequencer_if.slave   bus
);

   localparam logic [2:0] c_GET_A  = 3'b000;
   localparam logic [2:0] c_GET_OP = 3'b001;
   localparam logic [2:0] c_GET_B  = 3'b010;
   localparam logic [2:0] c_SETTLE = 3'b011;
   localparam logic [2:0] c_SHOW   = 3'b100;

   localparam logic [2:0] c_OP_NOT = 3'b010;
   localparam logic [2:0] c_OP_DIV = 3'b111;

   // The counter spans the whole settle window; capture happens on the edge
   // after it has reached zero, giving SETTLE_CYCLES+1 edges from final enter.
   localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);

   logic [2:0] r_state;
   logic [2:0] w_next_state;
   logic [3:0] r_cnt;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic [2:0] r_op;
   logic [3:0] r_result;
   logic       r_result_valid;
   logic       r_err;

   logic       w_capture;
   logic       w_div_zero;
   logic       w_op_is_not;

   assign w_capture   = (r_state == c_SETTLE) && (r_cnt == 4'd0);
   assign w_div_zero  = (r_op == c_OP_DIV) && (r_b == 4'd0);
   assign w_op_is_not = (bus.sw[2:0] == c_OP_NOT);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_GET_A;
      end else begin
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      if (bus.clear) begin
         w_next_state = c_GET_A;
      end else begin
         case (r_state)
            c_GET_A:  if (bus.enter) w_next_state = c_GET_OP;
            c_GET_OP: if (bus.enter) w_next_state = w_op_is_not ? c_SETTLE : c_GET_B;
            c_GET_B:  if (bus.enter) w_next_state = c_SETTLE;
            c_SETTLE: if (r_cnt == 4'd0) w_next_state = c_SHOW;
            c_SHOW:   if (bus.enter) w_next_state = c_GET_OP;
            default:  w_next_state = c_GET_A;
         endcase
      end
   end

   // ----------------------------------------------------------- datapath regs
   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         r_cnt          <= 4'd0;
         r_a            <= 4'd0;
         r_b            <= 4'd0;
         r_op           <= 3'd0;
         r_result       <= 4'd0;
         r_result_valid <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         case (r_state)
            c_GET_A: begin
               if (bus.enter) r_a <= bus.sw;
            end
            c_GET_OP: begin
               if (bus.enter) begin
                  r_op <= bus.sw[2:0];
                  if (w_op_is_not) begin
                     r_b   <= 4'd0;
                     r_cnt <= c_SETTLE_LOAD;
                  end
               end
            end
            c_GET_B: begin
               if (bus.enter) begin
                  r_b   <= bus.sw;
                  r_cnt <= c_SETTLE_LOAD;
               end
            end
            c_SETTLE: begin
               if (w_capture) begin
                  r_result       <= w_div_zero ? 4'd0 : bus.calc_out;
                  r_err          <= w_div_zero;
                  r_result_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            c_SHOW: begin
               // chain the held result in as the next A operand
               if (bus.enter) begin
                  r_a            <= r_result;
                  r_result_valid <= 1'b0;
                  r_err          <= 1'b0;
               end
            end
            default: begin
               r_cnt <= 4'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      bus.stage        = r_state;
      bus.a            = r_a;
      bus.b            = r_b;
      bus.op           = r_op;
      bus.result       = r_result;
      bus.result_valid = r_result_valid;
      bus.err          = r_err;
   end

endmodule

`default_nettype wire

// File: tb/tb_calc_operand_sequencer.sv
// ============================================================================
// tb_calc_operand_sequencer : directed + random bench with an edge-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_calc_operand_sequencer;

   localparam int S = 2;

   logic clk;
   logic rst_n;
   calc_operand_sequencer_if ifc ();

   calc_operand_sequencer #(.SETTLE_CYCLES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] calc(input logic [3:0] x, input logic [3:0] y,
                                       input logic [2:0] o);
      case (o)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return ~x;
         3'd3: return x ^ y;
         3'd4: return x + y;
         3'd5: return x - y;
         3'd6: return 4'((x * y) & 8'h0F);
         default: return (y == 4'd0) ? 4'd0 : x / y;
      endcase
   endfunction

   // calculator block the sequencer drives
   assign ifc.calc_out = calc(ifc.a, ifc.b, ifc.op);

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model: capture scheduled by absolute edge index
   logic [3:0] m_a, m_b, m_res;
   logic [2:0] m_op, m_stage;
   logic       m_rv, m_err;
   bit         m_live = 1'b0;
   int         cyc = 0;
   int         cap = -1;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n || ifc.clear) begin
         if (!rst_n) m_live <= 1'b1;
         m_stage <= 3'd0; m_a <= 0; m_b <= 0; m_op <= 0;
         m_res <= 0; m_rv <= 0; m_err <= 0; cap <= -1;
      end else begin
         case (m_stage)
            3'd0: if (ifc.enter) begin m_a <= ifc.sw; m_stage <= 3'd1; end
            3'd1: if (ifc.enter) begin
               m_op <= ifc.sw[2:0];
               if (ifc.sw[2:0] == 3'd2) begin
                  m_b <= 0; m_stage <= 3'd3; cap <= cyc + S + 1;
               end else m_stage <= 3'd2;
            end
            3'd2: if (ifc.enter) begin
               m_b <= ifc.sw; m_stage <= 3'd3; cap <= cyc + S + 1;
            end
            3'd3: if (cyc == cap) begin
               m_stage <= 3'd4; m_rv <= 1'b1;
               if (m_op == 3'd7 && m_b == 4'd0) begin m_res <= 0; m_err <= 1'b1; end
               else begin m_res <= calc(m_a, m_b, m_op); m_err <= 1'b0; end
            end
            3'd4: if (ifc.enter) begin
               m_a <= m_res; m_rv <= 0; m_err <= 0; m_stage <= 3'd1;
            end
            default: m_stage <= 3'd0;
         endcase
      end
   end

   // ---------------- per-cycle compare against the model
   always @(negedge clk) begin
      if (m_live) begin
         chk("stage",        ifc.stage,        m_stage);
         chk("a",            ifc.a,            m_a);
         chk("b",            ifc.b,            m_b);
         chk("op",           ifc.op,           m_op);
         chk("result",       ifc.result,       m_res);
         chk("result_valid", ifc.result_valid, m_rv);
         chk("err",          ifc.err,          m_err);
      end
   end

   // ---------------- stimulus
   task automatic cyc1(input logic r, input logic [3:0] s, input logic e, input logic c);
      rst_n = r; ifc.sw = s; ifc.enter = e; ifc.clear = c;
      @(posedge clk);
      #1;
      rst_n = 1'b1; ifc.enter = 1'b0; ifc.clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc1(1'b1, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic run3(input logic [3:0] x, input logic [3:0] o, input logic [3:0] y);
      cyc1(1'b1, x, 1'b1, 1'b0);
      cyc1(1'b1, o, 1'b1, 1'b0);
      cyc1(1'b1, y, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; ifc.sw = 4'd0; ifc.enter = 1'b0; ifc.clear = 1'b0;
      cyc1(1'b0, 4'd0, 1'b0, 1'b0);
      cyc1(1'b0, 4'd0, 1'b1, 1'b1);
      chk("rst_stage", ifc.stage, 0);
      chk("rst_a", ifc.a, 0);
      chk("rst_result_valid", ifc.result_valid, 0);
      chk("rst_err", ifc.err, 0);

      // ADD with exact latency
      cyc1(1'b1, 4'd3, 1'b1, 1'b0);
      chk("add_a", ifc.a, 3);
      cyc1(1'b1, 4'b0100, 1'b1, 1'b0);
      chk("add_op", ifc.op, 4);
      chk("add_stage_getb", ifc.stage, 2);
      cyc1(1'b1, 4'd4, 1'b1, 1'b0);
      chk("add_b", ifc.b, 4);
      chk("add_stage_settle", ifc.stage, 3);
      idle(S);
      chk("add_not_early", ifc.result_valid, 0);
      idle(1);
      chk("add_result", ifc.result, 7);
      chk("add_valid", ifc.result_valid, 1);
      chk("add_stage_show", ifc.stage, 4);

      // SUB / MULT wrap
      cyc1(1'b1, 4'd0, 1'b0, 1'b1);
      run3(4'd2, 4'b0101, 4'd5); idle(S + 1);
      chk("sub_wrap", ifc.result, 13);
      chk("sub_err", ifc.err, 0);
      cyc1(1'b1, 4'd0, 1'b0, 1'b1);
      run3(4'd5, 4'b1110, 4'd6); idle(S + 1);   // bit 3 of op switch ignored
      chk("mult_op", ifc.op, 6);
      chk("mult_wrap", ifc.result, 14);

      // NOT skips GET_B
      cyc1(1'b1, 4'd0, 1'b0, 1'b1);
      cyc1(1'b1, 4'd5, 1'b1, 1'b0);
      chk("not_stage_op", ifc.stage, 1);
      cyc1(1'b1, 4'b0010, 1'b1, 1'b0);
      chk("not_stage_settle", ifc.stage, 3);
      chk("not_b", ifc.b, 0);
      idle(S + 1);
      chk("not_result", ifc.result, 10);

      // divide by zero then chain
      cyc1(1'b1, 4'd0, 1'b0, 1'b1);
      run3(4'd9, 4'b0111, 4'd0); idle(S + 1);
      chk("div0_result", ifc.result, 0);
      chk("div0_err", ifc.err, 1);
      chk("div0_valid", ifc.result_valid, 1);
      cyc1(1'b1, 4'd0, 1'b1, 1'b0);
      chk("div0_chain_a", ifc.a, 0);
      chk("div0_chain_err", ifc.err, 0);
      chk("div0_chain_stage", ifc.stage, 1);

      // chaining 3+4=7, +2 = 9
      cyc1(1'b1, 4'd0, 1'b0, 1'b1);
      run3(4'd3, 4'b0100, 4'd4); idle(S + 1);
      cyc1(1'b1, 4'd0, 1'b1, 1'b0);
      chk("chain_a", ifc.a, 7);
      cyc1(1'b1, 4'b0100, 1'b1, 1'b0);
      cyc1(1'b1, 4'd2, 1'b1, 1'b0);
      idle(S + 1);
      chk("chain_result", ifc.result, 9);

      // clear in the second SETTLE cycle aborts capture
      cyc1(1'b1, 4'd0, 1'b0, 1'b1);
      run3(4'd1, 4'b0100, 4'd1);
      idle(1);
      cyc1(1'b1, 4'd0, 1'b0, 1'b1);
      chk("clr_stage", ifc.stage, 0);
      chk("clr_a", ifc.a, 0);
      idle(S + 2);
      chk("clr_no_capture", ifc.result_valid, 0);
      chk("clr_result", ifc.result, 0);

      // enter + clear together in GET_A
      cyc1(1'b1, 4'd9, 1'b1, 1'b1);
      chk("clr_wins_a", ifc.a, 0);
      chk("clr_wins_stage", ifc.stage, 0);

      // reset during SHOW
      run3(4'd3, 4'b0100, 4'd4); idle(S + 1);
      chk("pre_rst_valid", ifc.result_valid, 1);
      cyc1(1'b0, 4'd0, 1'b1, 1'b0);
      chk("rst_show_result", ifc.result, 0);
      chk("rst_show_valid", ifc.result_valid, 0);
      chk("rst_show_stage", ifc.stage, 0);
      chk("rst_show_op", ifc.op, 0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         cyc1(($urandom_range(0, 99) != 0),
              4'($urandom_range(0, 15)),
              ($urandom_range(0, 99) < 40),
              ($urandom_range(0, 99) < 4));
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
